counter_arbiter: RTL and testbench
==================================

// Module: counter_arbiter
// PURPOSE
//   Shares one up/down counter (2-bit control: 00 hold, 01 inc, 10 dec, 11 clear)
//   between N requesters. Round-robin arbitration with a req/gnt handshake.
//   Each op is checked against the counter's current value, so the shared count
//   never wraps. Sits between requesting FSMs and the counter, driving its
//   control input and reading its count output back.
// PARAMETERS
//   N  4  number of requesters, 2..16
//   W  4  counter width; must equal the width of the controlled counter
// PORTS
//   clk       in   1    clock
//   rst       in   1    synchronous, active-high reset
//   req       in   N    request per requester; held until gnt or rej
//   op        in   2N   requested op, requester i at op[2i+1:2i]; same encoding as ctrl
//   count_in  in   W    current counter value, fed back from the counter
//   ctrl      out  2    counter control, registered
//   gnt       out  N    one-hot, 1-cycle pulse: op accepted and issued
//   rej       out  N    one-hot, 1-cycle pulse: op refused (would wrap)
//   busy      out  1    high in ISSUE and SETTLE
// BEHAVIOUR
//   Reset: state=IDLE, ptr=0, ctrl=00, gnt=0, rej=0, busy=0. Reset mid-op aborts:
//     ctrl=00 and no gnt/rej in the cycle after rst; a pending op is dropped.
//   FSM: IDLE -> ISSUE -> SETTLE -> IDLE. At most one op per 3 cycles.
//   IDLE: ctrl=00. If req!=0, winner w = first set req at or after ptr, scanning
//     upward mod N. Latch w and op[w]. Set refuse = (op==01 && count_in=={W{1}})
//     || (op==10 && count_in==0). Go to ISSUE. If req==0, stay in IDLE.
//   ISSUE (1 cycle): if refuse, ctrl=00 and rej[w]=1; else ctrl=op and gnt[w]=1.
//     op 00 is granted with ctrl=00; op 11 is always granted.
//     ptr <= (w+1) mod N in both cases.
//   SETTLE (1 cycle): ctrl=00. The counter has updated, and the requester drops
//     or changes req. req is not sampled in this state.
//   Latency: req seen in IDLE at cycle t -> ctrl/gnt at t+1 -> count_in new at t+2.
//   Only the winner's req/op are latched. Changes on other lines are ignored
//     until the next IDLE.
//   req deasserted during ISSUE/SETTLE has no effect; the op is still issued.
//   gnt and rej are mutually exclusive; together they are one-hot or zero.
// CONFIGURATION
//   COUNTER_ARB_LOCK_EN defined: adds input lock[N-1:0]. If lock[w] is high in
//     SETTLE, ptr is set to w. A winner that keeps requesting therefore wins the
//     next IDLE, which allows atomic multi-op sequences. Refusals still apply.
//   Not defined: no lock port; strict round-robin as above.
// TESTING
//   rst, then req=0001 op0=01, count_in=0 -> ctrl=01 and gnt=0001 one cycle later;
//     SETTLE; ctrl=00.
//   req=1111, all ops=01, ptr=0 -> grants in order 0,1,2,3, then 0 again; 3 cycles each.
//   count_in=4'hF, req=0010 op1=01 -> rej=0010, ctrl stays 00, ptr=2.
//   count_in=0, req=0100 op2=10 -> rej=0100. The same request with op2=11 -> gnt=0100, ctrl=11.
//   rst asserted in the ISSUE cycle -> next cycle ctrl=00, gnt=rej=0, busy=0, ptr=0.
//   LOCK_EN: lock0=1, req=0011 -> requester 0 wins 3 times in a row; lock0=0 ->
//     requester 1 wins next.

Source files
------------

// File: rtl/counter_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : counter_arbiter
//  Purpose  : Round-robin req/gnt arbiter sharing one up/down counter among N
//             requesters. Refuses ops that would wrap the count.
//             Optional lock input enabled by defining COUNTER_ARB_LOCK_EN.
//  Revision : 1.0  initial release
// ============================================================================
module counter_arbiter #(
    parameter int N = 4,
    parameter int W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req_i,
    input  logic [2*N-1:0]   op_i,
    input  logic [W-1:0]     count_in_i,
`ifdef COUNTER_ARB_LOCK_EN
    input  logic [N-1:0]     lock_i,
`endif
    output logic [1:0]       ctrl_o,
    output logic [N-1:0]     gnt_o,
    output logic [N-1:0]     rej_o,
    output logic             busy_o
);

    localparam int IW = $clog2(N);

    localparam logic [1:0] C_OP_HOLD = 2'b00;
    localparam logic [1:0] C_OP_INC  = 2'b01;
    localparam logic [1:0] C_OP_DEC  = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_SETTLE = 2'd2
    } state_t;

    state_t          state_q;
    logic [IW-1:0]   ptr_q;
    logic [IW-1:0]   win_q;
    logic [1:0]      ctrl_q;
    logic [N-1:0]    gnt_q;
    logic [N-1:0]    rej_q;
    logic            busy_q;

    logic [IW-1:0]   w_win;
    logic            w_found;
    logic [IW:0]     w_idx;
    logic [1:0]      w_op;
    logic            w_refuse;
    logic [N-1:0]    w_onehot;
    logic [IW-1:0]   w_ptr_next;

    // First requester at or after ptr, scanning upward modulo N.
    always_comb begin
        w_win   = ptr_q;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < N; k++) begin
            w_idx = {1'b0, ptr_q} + (IW+1)'(k);
            if (w_idx >= (IW+1)'(N)) begin
                w_idx = w_idx - (IW+1)'(N);
            end
            if (!w_found && req_i[w_idx[IW-1:0]]) begin
                w_win   = w_idx[IW-1:0];
                w_found = 1'b1;
            end
        end
    end

    assign w_op       = op_i[{w_win, 1'b0} +: 2];
    assign w_refuse   = ((w_op == C_OP_INC) && (count_in_i == {W{1'b1}})) ||
                        ((w_op == C_OP_DEC) && (count_in_i == '0));
    assign w_onehot   = {{(N-1){1'b0}}, 1'b1} << w_win;
    assign w_ptr_next = (win_q == IW'(N-1)) ? '0 : win_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            ctrl_q  <= C_OP_HOLD;
            gnt_q   <= '0;
            rej_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    ctrl_q <= C_OP_HOLD;
                    gnt_q  <= '0;
                    rej_q  <= '0;
                    busy_q <= 1'b0;
                    if (w_found) begin
                        win_q   <= w_win;
                        busy_q  <= 1'b1;
                        state_q <= S_ISSUE;
                        // Outputs are registered, so the ISSUE response is loaded here.
                        if (w_refuse) begin
                            rej_q <= w_onehot;
                        end else begin
                            ctrl_q <= w_op;
                            gnt_q  <= w_onehot;
                        end
                    end
                end
                S_ISSUE: begin
                    ctrl_q  <= C_OP_HOLD;
                    gnt_q   <= '0;
                    rej_q   <= '0;
                    ptr_q   <= w_ptr_next;
                    state_q <= S_SETTLE;
                end
                S_SETTLE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
`ifdef COUNTER_ARB_LOCK_EN
                    if (lock_i[win_q]) begin
                        ptr_q <= win_q;
                    end
`endif
                end
                default: begin
                    ctrl_q  <= C_OP_HOLD;
                    gnt_q   <= '0;
                    rej_q   <= '0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ctrl_o = ctrl_q;
    assign gnt_o  = gnt_q;
    assign rej_o  = rej_q;
    assign busy_o = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_counter_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_counter_arbiter
//  Purpose  : Self-checking bench for counter_arbiter: vector table, directed
//             corner sequences and a randomized run against a reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_counter_arbiter;

    localparam int N = 4;
    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic [N-1:0] req;
    logic [7:0]   op;
    logic [W-1:0] cnt;
    logic [N-1:0] lock;
    logic [1:0]   ctrl;
    logic [N-1:0] gnt;
    logic [N-1:0] rej;
    logic         busy;

    int total = 0;
    int bad   = 0;

    counter_arbiter #(.N(N), .W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_i      (req),
        .op_i       (op),
        .count_in_i (cnt),
`ifdef COUNTER_ARB_LOCK_EN
        .lock_i     (lock),
`endif
        .ctrl_o     (ctrl),
        .gnt_o      (gnt),
        .rej_o      (rej),
        .busy_o     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic [7:0] op;
        logic [3:0] cnt;
        logic [1:0] ctrl;
        logic [3:0] gnt;
        logic [3:0] rej;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [3:0] apply_ctrl(input logic [3:0] c, input logic [1:0] ct);
        case (ct)
            2'b01:   return c + 4'd1;
            2'b10:   return c - 4'd1;
            2'b11:   return 4'd0;
            default: return c;
        endcase
    endfunction

    function automatic logic [1:0] rand_op();
        int r;
        r = $urandom_range(0, 9);
        if (r < 4) return 2'b01;
        if (r < 8) return 2'b10;
        if (r == 8) return 2'b11;
        return 2'b00;
    endfunction

    // Reference model state for the randomized run
    int         m_phase;
    int         m_ptr;
    int         m_win;
    logic [1:0] e_ctrl;
    logic [3:0] e_gnt;
    logic [3:0] e_rej;
    logic       e_busy;
    logic [1:0] ctrl_prev;
    logic [3:0] pend;
    logic [1:0] pop [4];

    initial begin
        vecs[0] = '{4'b0001, 8'b00_00_00_01, 4'h0, 2'b01, 4'b0001, 4'b0000};
        vecs[1] = '{4'b0010, 8'b00_00_01_00, 4'hF, 2'b00, 4'b0000, 4'b0010};
        vecs[2] = '{4'b0100, 8'b00_10_00_00, 4'h0, 2'b00, 4'b0000, 4'b0100};
        vecs[3] = '{4'b0100, 8'b00_11_00_00, 4'h0, 2'b11, 4'b0100, 4'b0000};
        vecs[4] = '{4'b1001, 8'b10_00_00_01, 4'h5, 2'b10, 4'b1000, 4'b0000};
        vecs[5] = '{4'b1001, 8'b10_00_00_01, 4'h5, 2'b01, 4'b0001, 4'b0000};
        vecs[6] = '{4'b0001, 8'b00_00_00_00, 4'h7, 2'b00, 4'b0001, 4'b0000};
        vecs[7] = '{4'b1100, 8'b01_10_00_00, 4'hF, 2'b10, 4'b0100, 4'b0000};
        vecs[8] = '{4'b1100, 8'b01_10_00_00, 4'hF, 2'b00, 4'b0000, 4'b1000};
        vecs[9] = '{4'b0110, 8'b00_11_10_00, 4'h0, 2'b00, 4'b0000, 4'b0010};

        rst = 1'b1; req = '0; op = '0; cnt = '0; lock = '0;
        repeat (3) step();
        chk("reset_ctrl", 32'(ctrl), 32'd0);
        chk("reset_gnt",  32'(gnt),  32'd0);
        chk("reset_rej",  32'(rej),  32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        rst = 1'b0;

        // Table: one complete transaction per record, ptr carries between records
        for (int i = 0; i < 10; i++) begin
            req = vecs[i].req; op = vecs[i].op; cnt = vecs[i].cnt;
            step();
            chk($sformatf("vec%0d_ctrl", i), 32'(ctrl), 32'(vecs[i].ctrl));
            chk($sformatf("vec%0d_gnt", i),  32'(gnt),  32'(vecs[i].gnt));
            chk($sformatf("vec%0d_rej", i),  32'(rej),  32'(vecs[i].rej));
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'd1);
            req = '0;
            step();
            chk($sformatf("vec%0d_settle_ctrl", i), 32'(ctrl), 32'd0);
            chk($sformatf("vec%0d_settle_pulse", i), 32'(gnt | rej), 32'd0);
            chk($sformatf("vec%0d_settle_busy", i), 32'(busy), 32'd1);
            step();
            chk($sformatf("vec%0d_idle_busy", i), 32'(busy), 32'd0);
        end

        // Round robin with all four requesting continuously
        rst = 1'b1; step(); rst = 1'b0;
        req = 4'b1111; op = 8'h55; cnt = 4'h0;
        for (int k = 0; k < 15; k++) begin
            step();
            chk($sformatf("rr%0d_gnt", k), 32'(gnt),
                (k % 3 == 0) ? (32'd1 << ((k / 3) % 4)) : 32'd0);
            chk($sformatf("rr%0d_ctrl", k), 32'(ctrl), (k % 3 == 0) ? 32'd1 : 32'd0);
        end
        req = '0;
        step();

        // Reset during ISSUE aborts the op and restores ptr to 0
        req = 4'b0001; op = 8'h01; cnt = 4'h3;
        step();
        chk("rstmid_issue_gnt", 32'(gnt), 32'b0001);
        rst = 1'b1;
        step();
        chk("rstmid_ctrl", 32'(ctrl), 32'd0);
        chk("rstmid_gnt",  32'(gnt),  32'd0);
        chk("rstmid_rej",  32'(rej),  32'd0);
        chk("rstmid_busy", 32'(busy), 32'd0);
        rst = 1'b0; req = 4'b0011; op = 8'h05;
        step();
        chk("rstmid_ptr0_gnt", 32'(gnt), 32'b0001);
        req = '0;
        step(); step();

`ifdef COUNTER_ARB_LOCK_EN
        rst = 1'b1; step(); rst = 1'b0;
        lock = 4'b0001; req = 4'b0011; op = 8'h00;
        for (int k = 0; k < 10; k++) begin
            step();
            chk($sformatf("lock%0d_gnt", k), 32'(gnt),
                (k == 0 || k == 3 || k == 6) ? 32'b0001 : (k == 9) ? 32'b0010 : 32'd0);
            if (k == 6) lock = 4'b0000;
        end
        req = '0;
        step(); step();
        lock = '0;
`endif

        // Randomized run against the transaction-level model
        rst = 1'b1; step(); rst = 1'b0;
        m_phase = 0; m_ptr = 0; m_win = 0;
        e_ctrl = '0; e_gnt = '0; e_rej = '0; e_busy = 1'b0;
        ctrl_prev = '0; pend = '0; cnt = 4'h8;
        for (int i = 0; i < N; i++) pop[i] = 2'b00;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            cnt = apply_ctrl(cnt, ctrl_prev);
            ctrl_prev = e_ctrl;
            for (int i = 0; i < N; i++) begin
                if (e_gnt[i] || e_rej[i]) pend[i] = 1'b0;
                if (!pend[i] && $urandom_range(0, 3) == 0) begin
                    pend[i] = 1'b1;
                    pop[i]  = rand_op();
                end
                op[2*i +: 2] = pend[i] ? pop[i] : 2'($urandom_range(0, 3));
            end
            req = pend;

            // Predict the next cycle from the current inputs
            e_ctrl = 2'b00; e_gnt = '0; e_rej = '0; e_busy = 1'b0;
            if (m_phase == 0) begin
                if (req != 0) begin
                    logic [1:0] o;
                    m_win = pick(req, m_ptr);
                    o = op[2*m_win +: 2];
                    e_busy = 1'b1;
                    if ((o == 2'b01 && cnt == 4'hF) || (o == 2'b10 && cnt == 4'h0)) begin
                        e_rej[m_win] = 1'b1;
                    end else begin
                        e_gnt[m_win] = 1'b1;
                        e_ctrl = o;
                    end
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                e_busy = 1'b1;
                m_ptr = (m_win + 1) % N;
                m_phase = 2;
            end else begin
                m_phase = 0;
            end

            step();
            chk("rnd_ctrl", 32'(ctrl), 32'(e_ctrl));
            chk("rnd_gnt",  32'(gnt),  32'(e_gnt));
            chk("rnd_rej",  32'(rej),  32'(e_rej));
            chk("rnd_busy", 32'(busy), 32'(e_busy));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
